pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It is the generalised successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). Each stage boundary instantiates one, and stall, flush and backpressure are handled uniformly instead of per stage. Control bits are separated from datapath bits so that a flushed or empty stage always presents a NOP to the next stage.

---
 rtl/pipe_stage_skid.sv | 129 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, flush and a NOP-gated control field.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and a registered in_ready.
module pipe_stage_skid #(
  parameter int CTRL_W = 7,
  parameter int DATA_W = 201
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              in_beat;
  logic              out_beat;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
`ifdef PIPE_STAGE_SKID_EN
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
`endif

  assign in_beat  = in_valid && in_ready;
  assign out_beat = out_valid && out_ready;

  // NOTE: sequential state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first, so no path through this block can infer a latch.
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_beat) state_nxt = FULL;
        FULL: begin
          if (!in_beat && out_beat) state_nxt = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
          else if (in_beat && !out_beat) state_nxt = SKID;
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: if (out_beat) state_nxt = FULL;
`endif
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (state != EMPTY);
    case (state)
      FULL:    occupancy = 2'd1;
      SKID:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
`ifdef PIPE_STAGE_SKID_EN
    // Derived only from the state register: no combinational out_ready -> in_ready path.
    in_ready = (state != SKID);
`else
    in_ready = !out_valid || out_ready;
`endif
    out_ctrl = out_valid ? main_ctrl : '0;
    out_data = main_data;
  end

  // NOTE: these are plain registers rather than a memory array, so clearing them on
  // reset/flush is cheap and gives the required zero out_data after invalidation.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_ctrl <= '0;
      main_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_ctrl <= '0;
      skid_data <= '0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (in_beat) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
        end
        FULL: begin
          if (in_beat && out_beat) begin
            main_ctrl <= in_ctrl;
            main_data <= in_data;
          end
`ifdef PIPE_STAGE_SKID_EN
          else if (in_beat) begin
            skid_ctrl <= in_ctrl;
            skid_data <= in_data;
          end
`endif
        end
`ifdef PIPE_STAGE_SKID_EN
        SKID: begin
          if (out_beat) begin
            main_ctrl <= skid_ctrl;
            main_data <= skid_data;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed plan steps followed by random traffic,
// checked every cycle against a bounded-FIFO reference model (works with or without PIPE_STAGE_SKID_EN).
module tb_pipe_stage_skid;

  localparam int CW = 7;
  localparam int DW = 201;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         q[$];
  logic [DW-1:0] last_data;
  int            checks;
  int            errors;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID_ON = 1'b1;
`else
  localparam bit SKID_ON = 1'b0;
`endif

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [223:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // One clock cycle: drive inputs after the falling edge, compare outputs against the model,
  // then advance the model by the handshakes that happen at the next rising edge.
  task automatic cycle(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                       input logic ordy, input logic fl, input logic r, input bit chk);
    bit            exp_valid;
    bit            exp_ready;
    logic [CW-1:0] exp_ctrl;
    logic [DW-1:0] exp_data;
    beat_t         b;
    @(negedge clk);
    rst = r; flush = fl; in_valid = iv; in_ctrl = ic; in_data = id; out_ready = ordy;
    #1;
    exp_valid = (q.size() > 0);
    exp_ctrl  = exp_valid ? q[0].c : '0;
    exp_data  = exp_valid ? q[0].d : last_data;
    exp_ready = SKID_ON ? (q.size() < 2) : (q.size() == 0 || ordy);
    if (chk) begin
      check("out_valid", 256'(out_valid), 256'(exp_valid));
      check("out_ctrl",  256'(out_ctrl),  256'(exp_ctrl));
      check("out_data",  256'(out_data),  256'(exp_data));
      check("occupancy", 256'(occupancy), 256'(q.size()));
      check("in_ready",  256'(in_ready),  256'(exp_ready));
    end
    b.c = ic;
    b.d = id;
    @(posedge clk);
    if (r || fl) begin
      q.delete();
      last_data = '0;
    end else begin
      if (exp_valid && ordy) void'(q.pop_front());
      if (iv && exp_ready) q.push_back(b);
    end
    if (q.size() > 0) last_data = q[0].d;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_data = '0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;

    // Reset with a live upstream beat that must be ignored
    cycle(1'b1, 7'h7F, DW'(5), 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 7'h7F, DW'(5), 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Streaming 1..8 at full rate
    for (int i = 1; i <= 8; i++) cycle(1'b1, CW'(i), DW'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Backpressure: A then B with out_ready low, hold, then release
    cycle(1'b1, 7'h0A, DW'(16'hAAAA), 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 7'h0B, DW'(16'hBBBB), 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Flush while full/skid with a concurrent beat C that must vanish
    cycle(1'b1, 7'h0A, DW'(16'hAAAA), 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 7'h0B, DW'(16'hBBBB), 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 7'h0C, DW'(16'hCCCC), 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Bubble gating: drain A normally, ctrl zeroed, data retained
    cycle(1'b1, 7'h11, DW'(16'hA5A5), 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);

    // FULL with out_ready low, then simultaneous in+out beat replacing the held one
    cycle(1'b1, 7'h21, DW'(16'h1111), 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 7'h22, DW'(16'h2222), 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Random traffic with occasional flush and mid-operation reset
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), CW'($urandom), rnd_data(),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 23) == 0),
            1'($urandom_range(0, 47) == 0), 1'b1);
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
